// File: rtl/circuit2_sched_pkg.sv
// Shared types for the resource-shared circuit2 scheduler: FSM states,
// ALU opcodes and the completed-evaluation counter width.
package circuit2_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S_D,
        S_E,
        S_F,
        S_OUT
    } state_t;

    typedef enum logic {
        ALU_ADD,
        ALU_SUB
    } alu_op_t;

    localparam int OPS_WIDTH = 16;

endpackage

// File: rtl/circuit2_sched_alu.sv
// Shared signed add/sub unit; every add and subtract of one evaluation
// passes through this single instance, wrapping modulo 2^DATAWIDTH.
module sched_alu
    import circuit2_sched_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  alu_op_t                     op,
    input  logic signed [DATAWIDTH-1:0] opa,
    input  logic signed [DATAWIDTH-1:0] opb,
    output logic signed [DATAWIDTH-1:0] res
);

    always_comb begin
        if (op == ALU_SUB) res = opa - opb;
        else               res = opa + opb;
    end

endmodule

// File: rtl/circuit2_sched.sv
// Multi-cycle circuit2 evaluator: one shared ALU, one comparator, Start/Busy/Done
// framing. Define SCHED_OPCOUNT_EN to add the Ops completed-evaluation counter.
module circuit2_sched
    import circuit2_sched_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Start,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] b,
    input  logic signed [DATAWIDTH-1:0] c,
    output logic                        Busy,
    output logic                        Done,
    output logic signed [DATAWIDTH-1:0] x,
    output logic signed [DATAWIDTH-1:0] z
`ifdef SCHED_OPCOUNT_EN
    ,
    output logic [OPS_WIDTH-1:0]        Ops
`endif
);

    state_t                      state;
    logic signed [DATAWIDTH-1:0] ra, rb, rc;
    logic signed [DATAWIDTH-1:0] rd, re, rf;
    logic                        rlt, req;

    alu_op_t                     aluOp;
    logic signed [DATAWIDTH-1:0] aluA, aluB, aluRes;
    logic signed [DATAWIDTH-1:0] g, h;

    // Operand/opcode steering for the shared ALU: S_E adds c, S_F subtracts b.
    always_comb begin
        aluOp = ALU_ADD;
        aluA  = ra;
        aluB  = rb;
        case (state)
            S_E:     aluB  = rc;
            S_F:     aluOp = ALU_SUB;
            default: ;
        endcase
    end

    sched_alu #(.DATAWIDTH(DATAWIDTH)) u_alu (
        .op  (aluOp),
        .opa (aluA),
        .opb (aluB),
        .res (aluRes)
    );

    always_comb begin
        g = rlt ? re : rd;
        h = req ? rf : g;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            x     <= '0;
            z     <= '0;
            ra    <= '0;
            rb    <= '0;
            rc    <= '0;
            rd    <= '0;
            re    <= '0;
            rf    <= '0;
            rlt   <= 1'b0;
            req   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        ra    <= a;
                        rb    <= b;
                        rc    <= c;
                        Busy  <= 1'b1;
                        state <= S_D;
                    end
                end
                S_D: begin
                    rd    <= aluRes;
                    state <= S_E;
                end
                S_E: begin
                    re    <= aluRes;
                    state <= S_F;
                end
                S_F: begin
                    rf    <= aluRes;
                    rlt   <= rd < re;
                    req   <= rd == re;
                    state <= S_OUT;
                end
                S_OUT: begin
                    x     <= rlt ? {g[DATAWIDTH-2:0], 1'b0} : g;
                    z     <= req ? {h[DATAWIDTH-1], h[DATAWIDTH-1:1]} : h;
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCHED_OPCOUNT_EN
    always_ff @(posedge Clk) begin
        if (Rst)                 Ops <= '0;
        else if (state == S_OUT) Ops <= Ops + 1'b1;
    end
`endif

endmodule

// File: doc/circuit2_sched.md
# circuit2_sched

Multi-cycle, resource-shared controller that evaluates the circuit2 dataflow (d=a+b, e=a+c, f=a−b, compare, mux, shift) using one shared signed add/sub unit and one comparator instead of three parallel adders. An FSM sequences operand capture, the three ALU operations, the compare and the output stage. A Start/Busy/Done handshake frames each evaluation. It sits in datapath-generator output wherever area matters more than the single-cycle latency of the fully parallel circuit2 netlist.

## Interface
- DATAWIDTH, 32, width of a, b, c, x, z and all internal temporaries (signed, two's complement)
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  synchronous reset, active-high
- Start  in  1  request a new evaluation; accepted only in IDLE
- a, b, c  in  DATAWIDTH  signed operands, sampled only in the accepting cycle
- Busy  out  1  high while an accepted evaluation is in progress
- Done  out  1  one-cycle pulse when x, z have been updated
- x  out  DATAWIDTH  signed result g << dLTe
- z  out  DATAWIDTH  signed result h >>> dEQe
- Ops  out  16  completed-evaluation count (only with SCHED_OPCOUNT_EN)

## Operation
- States: IDLE, S_D, S_E, S_F, S_OUT. IDLE→S_D on Start; S_D→S_E→S_F→S_OUT→IDLE unconditionally.
- IDLE with Start=1: register a, b, c into ra, rb, rc.
- S_D: shared ALU adds, rd = ra+rb.
- S_E: shared ALU adds, re = ra+rc.
- S_F: shared ALU subtracts, rf = ra−rb. Comparator on registered rd, re gives rlt = (rd<re) and req = (rd==re), both signed.
- S_OUT: g = rlt ? re : rd; h = req ? rf : g. x ← g shifted left by rlt (0 or 1 bit). z ← h arithmetic-shifted right by req (0 or 1 bit). Done ← 1.
- Arithmetic wraps modulo 2^DATAWIDTH with no saturation and no overflow flag. The comparator uses the wrapped values.
- Start is ignored in every non-IDLE state. Operands do not need to be held after the accepting cycle.
- x, z hold their last values between completions and change only on the S_OUT edge.
- Reset: state=IDLE, Busy=0, Done=0, x=0, z=0, Ops=0, internal registers=0. Reset during an evaluation aborts it with no Done pulse and x, z cleared.
- Rst and Start asserted together: reset wins and Start is not accepted.

## Timing
- Start sampled high at edge 0 (in IDLE). Busy is high in cycles 1–4, and Done plus the new x, z are visible in cycle 5. Latency is 5 cycles.
- Busy and Done are registered outputs. Busy=0 whenever Done=1.
- The FSM is in IDLE during the Done cycle, so a Start there is accepted. Back-to-back throughput is one evaluation per 5 cycles.
- Done is exactly one cycle wide.

## Configuration
- SCHED_OPCOUNT_EN defined:
  - Ops port exists.
  - It increments on each S_OUT edge, wraps 0xFFFF→0 and resets to 0.
- Undefined:
  - Ops port and counter are absent.
  - All other behaviour is identical.

## Structure
- Shared package holds:
  - the state enum (IDLE, S_D, S_E, S_F, S_OUT)
  - the ALU opcode type (ALU_ADD, ALU_SUB)
  - the ops-counter width constant (16)
- One sub-module, sched_alu: combinational signed add/sub of DATAWIDTH, opcode-selected, driven by FSM operand and opcode muxes. The comparator, mux and shift stay inline.

## Test plan
- a=5, b=3, c=1, Start → cycle 5: Done=1, x=8, z=8 (d=8, e=6, no lt, no eq).
- a=1, b=2, c=5 → x=12, z=6 (lt: g=e=6, shifted left by 1).
- a=4, b=2, c=2 → x=6, z=1 (eq: h=f=2, shifted right by 1); then a=−10, b=5, c=5 → x=−5, z=−8 (arithmetic shift).
- a=0x7FFFFFFF, b=1, c=0 → x=0xFFFFFFFE, z=0x7FFFFFFF (wrap: d negative so lt=1).
- Start held high continuously → Done every 5 cycles; Start pulses in S_D–S_OUT are ignored; Ops counts completions when SCHED_OPCOUNT_EN is defined.
- Rst asserted in S_E → next cycle IDLE, Busy=0, x=z=0, and no Done pulse.
